// File: rtl/ice_i2c_arb_pkg.sv
// ice_i2c_pkg: shared types and constants for the I2C master arbiter.
//   arb_state_t      - arbiter FSM state encoding
//   I2C_ADDR_W/DATA_W - 7-bit slave address, 8-bit data byte
//   ARB_GAP_DEF      - default bus-free gap between transactions (i_clk cycles)
//   ARB_TIMEOUT_DEF  - default watchdog limit for one transaction (i_clk cycles)
package ice_i2c_pkg;

    localparam int I2C_ADDR_W      = 7;
    localparam int I2C_DATA_W      = 8;
    localparam int ARB_GAP_DEF     = 256;
    localparam int ARB_TIMEOUT_DEF = 8192;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ice_i2c_arb_rr.sv
// ice_rr_arb: combinational round-robin picker.
//   req - per-requester request bits
//   ptr - index of the last winner; search starts at ptr+1 (mod N)
//   gnt - one-hot winner (all zero when req is zero)
//   idx - encoded winner index (0 when req is zero)
module ice_rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IDX_W = $clog2(N);

    logic             found;
    logic [IDX_W-1:0] cand;

    // i runs 1..N so the previous winner is considered last.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/ice_i2c_arb.sv
// ice_i2c_arb: shares one ice_i2c master between N requesters.
// A round-robin winner's address/data/direction is captured at grant and
// presented to the master with o_m_valid held for the whole transaction.
// Completion returns a one-cycle o_ack (with o_rdata); a watchdog aborts a
// hung transaction with a one-cycle o_err. A GAP-cycle bus-free interval
// follows every transaction, during which the grant is still held.
//
// Ports:
//   i_clk, i_nrst            clock, asynchronous active-low reset
//   i_req[N]                 level requests
//   i_addr[7N], i_wdata[8N]  per-requester address / write byte
//   i_rnw[N]                 per-requester direction (1 = read)
//   o_ack[N], o_err[N]       one-hot completion / timeout pulses
//   o_rdata[8]               read byte, valid with o_ack
//   o_gnt[N]                 one-hot grant over BUSY and GAP
//   o_m_addr/data/rnw/valid  request to the master
//   i_m_data, i_m_accept     response from the master
//
// state    | meaning
// ---------+---------------------------------------------------------
// ARB_IDLE | no owner; grant the next round-robin requester
// ARB_BUSY | o_m_valid high, waiting for i_m_accept or watchdog
// ARB_GAP  | o_m_valid low for GAP cycles, grant still held
module ice_i2c_arb
    import ice_i2c_pkg::*;
#(
    parameter int N       = 4,
    parameter int GAP     = ARB_GAP_DEF,
    parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_nrst,
    input  logic [N-1:0]            i_req,
    input  logic [I2C_ADDR_W*N-1:0] i_addr,
    input  logic [I2C_DATA_W*N-1:0] i_wdata,
    input  logic [N-1:0]            i_rnw,
    output logic [N-1:0]            o_ack,
    output logic [N-1:0]            o_err,
    output logic [I2C_DATA_W-1:0]   o_rdata,
    output logic [N-1:0]            o_gnt,
    output logic [I2C_ADDR_W-1:0]   o_m_addr,
    output logic [I2C_DATA_W-1:0]   o_m_data,
    output logic                    o_m_rnw,
    output logic                    o_m_valid,
    input  logic [I2C_DATA_W-1:0]   i_m_data,
    input  logic                    i_m_accept
);

    localparam int IDX_W = $clog2(N);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int GAP_W = $clog2(GAP + 1);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [TMR_W-1:0] timer;
    logic [GAP_W-1:0] gap_cnt;
    logic [N-1:0]     win_gnt;
    logic [IDX_W-1:0] win_idx;

    ice_rr_arb #(.N(N)) u_rr (
        .req (i_req),
        .ptr (ptr),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state     <= ARB_IDLE;
            ptr       <= IDX_W'(N - 1);
            timer     <= '0;
            gap_cnt   <= '0;
            o_ack     <= '0;
            o_err     <= '0;
            o_rdata   <= '0;
            o_gnt     <= '0;
            o_m_addr  <= '0;
            o_m_data  <= '0;
            o_m_rnw   <= 1'b0;
            o_m_valid <= 1'b0;
        end else begin
            o_ack <= '0;
            o_err <= '0;
            case (state)
                ARB_IDLE: begin
                    if (|i_req) begin
                        o_m_addr  <= i_addr[int'(win_idx)*I2C_ADDR_W +: I2C_ADDR_W];
                        o_m_data  <= i_wdata[int'(win_idx)*I2C_DATA_W +: I2C_DATA_W];
                        o_m_rnw   <= i_rnw[win_idx];
                        o_gnt     <= win_gnt;
                        ptr       <= win_idx;
                        timer     <= '0;
                        o_m_valid <= 1'b1;
                        state     <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // Accept is tested first so it wins over a simultaneous timeout.
                    if (i_m_accept) begin
                        o_ack     <= o_gnt;
                        o_rdata   <= i_m_data;
                        o_m_valid <= 1'b0;
                        gap_cnt   <= '0;
                        state     <= ARB_GAP;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        o_err     <= o_gnt;
                        o_m_valid <= 1'b0;
                        gap_cnt   <= '0;
                        state     <= ARB_GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ARB_GAP: begin
                    if (gap_cnt == GAP_W'(GAP - 1)) begin
                        o_gnt <= '0;
                        state <= ARB_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    o_m_valid <= 1'b0;
                    o_gnt     <= '0;
                    state     <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ice_i2c_arb.sv
// Directed bench for ice_i2c_arb with default parameters (N=4, GAP=256,
// TIMEOUT=8192). Inputs are driven and outputs sampled on the falling edge.
module tb_ice_i2c_arb;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic [3:0]  req;
    logic [27:0] addr;
    logic [31:0] wdata;
    logic [3:0]  rnw;
    logic [3:0]  ack, err, gnt;
    logic [7:0]  rdata, m_data, mdata_in;
    logic [6:0]  m_addr;
    logic        m_rnw, m_valid, accept;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ice_i2c_arb #(.N(N)) dut (
        .i_clk      (clk),
        .i_nrst     (nrst),
        .i_req      (req),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .i_rnw      (rnw),
        .o_ack      (ack),
        .o_err      (err),
        .o_rdata    (rdata),
        .o_gnt      (gnt),
        .o_m_addr   (m_addr),
        .o_m_data   (m_data),
        .o_m_rnw    (m_rnw),
        .o_m_valid  (m_valid),
        .i_m_data   (mdata_in),
        .i_m_accept (accept)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        nrst = 1'b0; req = '0; accept = 1'b0; mdata_in = '0; rnw = '0;
        tick(2);
        nrst = 1'b1;
        tick(1);
    endtask

    // Returns ok=1 and the number of ticks taken once o_m_valid is seen high.
    task automatic wait_valid(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 1000; i++) begin
            if (m_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; req = '0; accept = 1'b0; mdata_in = 8'hFF; rnw = '0;
        addr = '0; wdata = '0;
        tick(2);
        total++;
        if ({ack, err, rdata, gnt, m_addr, m_data, m_rnw, m_valid} !== '0)
            $display("FAIL reset_outputs: got %h want 0",
                     {ack, err, rdata, gnt, m_addr, m_data, m_rnw, m_valid});
        else passed++;
        nrst = 1'b1;
        tick(3);
        total++;
        if ({m_valid, gnt} !== 5'b0) $display("FAIL reset_idle: got %b want 0", {m_valid, gnt});
        else passed++;
    endtask

    task automatic test_single_write();
        bit stable, low_ok;
        do_reset();
        addr[6:0] = 7'h48; wdata[7:0] = 8'hA5; rnw = '0; req = 4'b0001;
        total++;
        if (m_valid !== 1'b0) $display("FAIL wr_valid_early: got %b want 0", m_valid);
        else passed++;
        tick();
        total++;
        if ({m_valid, gnt, m_addr, m_data, m_rnw} !== {1'b1, 4'b0001, 7'h48, 8'hA5, 1'b0})
            $display("FAIL wr_grant: got %b %b %h %h %b want 1 0001 48 a5 0",
                     m_valid, gnt, m_addr, m_data, m_rnw);
        else passed++;
        addr[6:0] = 7'h11; wdata[7:0] = 8'h00;
        stable = 1'b1;
        for (int k = 1; k < 3900; k++) begin
            tick();
            if (m_valid !== 1'b1 || m_addr !== 7'h48 || m_data !== 8'hA5 || ack !== 4'b0)
                stable = 1'b0;
        end
        accept = 1'b1; mdata_in = 8'h77;
        tick();
        accept = 1'b0; req = '0;
        total++;
        if (stable !== 1'b1) $display("FAIL wr_stable: got %b want 1", stable);
        else passed++;
        total++;
        if ({ack, m_valid, rdata, gnt} !== {4'b0001, 1'b0, 8'h77, 4'b0001})
            $display("FAIL wr_ack: got %b %b %h %b want 0001 0 77 0001", ack, m_valid, rdata, gnt);
        else passed++;
        low_ok = 1'b1;
        for (int k = 1; k < 256; k++) begin
            tick();
            if (m_valid !== 1'b0 || gnt !== 4'b0001 || ack !== 4'b0) low_ok = 1'b0;
        end
        total++;
        if (low_ok !== 1'b1) $display("FAIL wr_gap_hold: got %b want 1", low_ok);
        else passed++;
        tick();
        total++;
        if (gnt !== 4'b0) $display("FAIL wr_gap_end: got %b want 0000", gnt);
        else passed++;
    endtask

    task automatic test_round_robin();
        bit ok;
        int n;
        int exp_idx;
        logic [3:0] exp_gnt;
        do_reset();
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_idx = t % 4;
            exp_gnt = 4'b0001 << exp_idx;
            wait_valid(ok, n);
            total++;
            if (!ok || gnt !== exp_gnt)
                $display("FAIL rr_grant_%0d: got %b ok=%0d want %b", t, gnt, ok, exp_gnt);
            else passed++;
            if (t > 0) begin
                total++;
                if (n + 1 !== 257) $display("FAIL rr_spacing_%0d: got %0d want 257", t, n + 1);
                else passed++;
            end
            tick(10);
            accept = 1'b1; mdata_in = 8'(t);
            tick();
            accept = 1'b0;
            total++;
            if (ack !== exp_gnt) $display("FAIL rr_ack_%0d: got %b want %b", t, ack, exp_gnt);
            else passed++;
            req[exp_idx] = 1'b0;
            tick();
            req[exp_idx] = 1'b1;
        end
        req = '0;
    endtask

    task automatic test_read();
        bit ok;
        int n;
        do_reset();
        addr[20:14] = 7'h20; rnw = 4'b0100; req = 4'b0100;
        wait_valid(ok, n);
        total++;
        if (!ok || {gnt, m_rnw, m_addr} !== {4'b0100, 1'b1, 7'h20})
            $display("FAIL rd_grant: got %b %b %h want 0100 1 20", gnt, m_rnw, m_addr);
        else passed++;
        tick(20);
        accept = 1'b1; mdata_in = 8'h3C;
        tick();
        accept = 1'b0; mdata_in = 8'h00; req = '0;
        total++;
        if ({ack, rdata} !== {4'b0100, 8'h3C})
            $display("FAIL rd_ack: got %b %h want 0100 3c", ack, rdata);
        else passed++;
        tick();
        total++;
        if ({ack, rdata} !== {4'b0000, 8'h3C})
            $display("FAIL rd_pulse: got %b %h want 0000 3c", ack, rdata);
        else passed++;
        rnw = '0;
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        do_reset();
        addr[13:7] = 7'h55; req = 4'b0010; mdata_in = 8'hE1;
        wait_valid(ok, n);
        total++;
        if (!ok || gnt !== 4'b0010) $display("FAIL to_grant: got %b want 0010", gnt);
        else passed++;
        tick(8191);
        total++;
        if ({err, m_valid} !== {4'b0000, 1'b1})
            $display("FAIL to_early: got %b %b want 0000 1", err, m_valid);
        else passed++;
        tick();
        req = '0;
        total++;
        if ({err, ack, m_valid, rdata} !== {4'b0010, 4'b0000, 1'b0, 8'h00})
            $display("FAIL to_err: got %b %b %b %h want 0010 0000 0 00", err, ack, m_valid, rdata);
        else passed++;
        tick(5);
        accept = 1'b1; mdata_in = 8'h99;
        tick();
        accept = 1'b0;
        total++;
        if ({ack, err, rdata} !== {4'b0, 4'b0, 8'h00})
            $display("FAIL to_stray_accept: got %b %b %h want 0000 0000 00", ack, err, rdata);
        else passed++;
        tick(249);
        total++;
        if (gnt !== 4'b0010) $display("FAIL to_gap_hold: got %b want 0010", gnt);
        else passed++;
        tick();
        total++;
        if (gnt !== 4'b0) $display("FAIL to_idle: got %b want 0000", gnt);
        else passed++;
    endtask

    task automatic test_accept_at_timeout();
        bit ok;
        int n;
        do_reset();
        req = 4'b1000;
        wait_valid(ok, n);
        total++;
        if (!ok || gnt !== 4'b1000) $display("FAIL at_grant: got %b want 1000", gnt);
        else passed++;
        tick(8191);
        accept = 1'b1; mdata_in = 8'h5A;
        tick();
        accept = 1'b0; req = '0;
        total++;
        if ({ack, err, rdata, m_valid} !== {4'b1000, 4'b0000, 8'h5A, 1'b0})
            $display("FAIL at_ack: got %b %b %h %b want 1000 0000 5a 0", ack, err, rdata, m_valid);
        else passed++;
        tick();
        total++;
        if (err !== 4'b0) $display("FAIL at_no_err: got %b want 0000", err);
        else passed++;
    endtask

    task automatic test_reset_and_drop();
        bit ok;
        int n;
        do_reset();
        req = 4'b0010;
        wait_valid(ok, n);
        total++;
        if (!ok || gnt !== 4'b0010) $display("FAIL rs_grant: got %b want 0010", gnt);
        else passed++;
        tick(100);
        #2 nrst = 1'b0;
        #1;
        total++;
        if ({ack, err, rdata, gnt, m_addr, m_data, m_rnw, m_valid} !== '0)
            $display("FAIL rs_async: got %h want 0",
                     {ack, err, rdata, gnt, m_addr, m_data, m_rnw, m_valid});
        else passed++;
        tick(2);
        nrst = 1'b1; req = 4'b0011;
        tick();
        wait_valid(ok, n);
        total++;
        if (!ok || gnt !== 4'b0001) $display("FAIL rs_ptr: got %b want 0001", gnt);
        else passed++;
        tick(10);
        req = 4'b0010;
        tick(40);
        accept = 1'b1;
        tick();
        accept = 1'b0;
        total++;
        if (ack !== 4'b0001) $display("FAIL drop_ack: got %b want 0001", ack);
        else passed++;
        tick();
        wait_valid(ok, n);
        total++;
        if (!ok || gnt !== 4'b0010) $display("FAIL drop_next: got %b want 0010", gnt);
        else passed++;
        req = '0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_read();
        test_timeout();
        test_accept_at_timeout();
        test_reset_and_drop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
